// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: port indices, port count
// and the access legality check (word alignment plus depth range).
package mem_arb_pkg;

  localparam int NPORT = 3;

  localparam logic [1:0] PORT_IF  = 2'd0;
  localparam logic [1:0] PORT_LS  = 2'd1;
  localparam logic [1:0] PORT_DBG = 2'd2;

  // An access is legal when the byte address is even and its word index
  // (address shifted right by one) lies inside the memory depth.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] depth);
    logic aligned;
    logic in_range;
    aligned  = (addr[0] == 1'b0);
    in_range = ((addr >> 1) < depth);
    return aligned && in_range;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter core. Purely combinational: the caller keeps
// the last-granted index and feeds it back in. The search starts at the port
// after the last winner and wraps around.
module rr_arb3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

  logic [1:0] first_s;
  logic [1:0] second_s;
  logic [1:0] third_s;

  // Build the search order from the last winner: last+1, last+2, last+3 (mod 3).
  always_comb begin
    first_s  = PORT_IF;
    second_s = PORT_LS;
    third_s  = PORT_DBG;
    case (last)
      PORT_IF: begin
        first_s  = PORT_LS;
        second_s = PORT_DBG;
        third_s  = PORT_IF;
      end
      PORT_LS: begin
        first_s  = PORT_DBG;
        second_s = PORT_IF;
        third_s  = PORT_LS;
      end
      default: begin
        first_s  = PORT_IF;
        second_s = PORT_LS;
        third_s  = PORT_DBG;
      end
    endcase
  end

  // Pick the first requesting port in search order and encode it one-hot.
  always_comb begin
    idx = 2'd0;
    gnt = 3'b000;
    if (req[first_s]) begin
      idx = first_s;
      gnt = 3'b001 << first_s;
    end else if (req[second_s]) begin
      idx = second_s;
      gnt = 3'b001 << second_s;
    end else if (req[third_s]) begin
      idx = third_s;
      gnt = 3'b001 << third_s;
    end else begin
      idx = 2'd0;
      gnt = 3'b000;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port 64x16 unified memory shared by instruction
// fetch, load/store and debug/loader. One access per cycle, round-robin
// winner, responses (rvalid/wack/err/rdata) registered one cycle later.
// Misaligned or out-of-range accesses are granted but never reach memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic [2:0]      wack,
  output logic            mem_we,
  output logic [AW-1:0]   mem_a,
  output logic [DW-1:0]   mem_wd,
  input  logic [DW-1:0]   mem_rd
);

  logic [1:0]    last_q,   last_d;
  logic [2:0]    rvalid_q, rvalid_d;
  logic [2:0]    wack_q,   wack_d;
  logic          err_q,    err_d;
  logic [DW-1:0] rdata_q,  rdata_d;

  logic [2:0]    gnt_raw_s;
  logic [1:0]    idx_s;
  logic [2:0]    gnt_s;
  logic          win_valid_s;
  logic          win_we_s;
  logic          win_legal_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_wdata_s;

  rr_arb3 u_rr_arb3 (
    .req  (req),
    .last (last_q),
    .gnt  (gnt_raw_s),
    .idx  (idx_s)
  );

  // Suppress any grant while reset is held so no memory access can leak out.
  always_comb begin
    if (rst_n) begin
      gnt_s = gnt_raw_s;
    end else begin
      gnt_s = 3'b000;
    end
    win_valid_s = |gnt_s;
  end

  // Select the winning requester's command fields.
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    case (idx_s)
      PORT_IF: begin
        win_we_s    = we[0];
        win_addr_s  = addr[0*AW +: AW];
        win_wdata_s = wdata[0*DW +: DW];
      end
      PORT_LS: begin
        win_we_s    = we[1];
        win_addr_s  = addr[1*AW +: AW];
        win_wdata_s = wdata[1*DW +: DW];
      end
      PORT_DBG: begin
        win_we_s    = we[2];
        win_addr_s  = addr[2*AW +: AW];
        win_wdata_s = wdata[2*DW +: DW];
      end
      default: begin
        win_we_s    = 1'b0;
        win_addr_s  = '0;
        win_wdata_s = '0;
      end
    endcase
    win_legal_s = addr_legal(32'(win_addr_s), 32'(DEPTH));
  end

  // Memory-side drive: only a granted, legal write may assert mem_we.
  always_comb begin
    gnt = gnt_s;
    if (win_valid_s) begin
      mem_we = win_we_s & win_legal_s;
      mem_a  = win_addr_s;
      mem_wd = win_wdata_s;
    end else begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
    end
  end

  // Next-state for the pointer and the one-cycle response pulses.
  always_comb begin
    last_d   = last_q;
    rvalid_d = 3'b000;
    wack_d   = 3'b000;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    if (win_valid_s) begin
      last_d = idx_s;
      err_d  = ~win_legal_s;
      if (win_we_s) begin
        wack_d = gnt_s;
      end else begin
        rvalid_d = gnt_s;
        if (win_legal_s) begin
          rdata_d = mem_rd;
        end else begin
          rdata_d = '0;
        end
      end
    end else begin
      last_d = last_q;
    end
  end

  // State registers; reset drops any response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= PORT_DBG;
      rvalid_q <= 3'b000;
      wack_q   <= 3'b000;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      wack_q   <= wack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Registered response outputs.
  always_comb begin
    rvalid = rvalid_q;
    wack   = wack_q;
    err    = err_q;
    rdata  = rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-free behavioural model (rotating priority + shadow memory).
module tb_mem_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            err;
  logic [2:0]      wack;
  logic            mem_we;
  logic [AW-1:0]   mem_a;
  logic [DW-1:0]   mem_wd;
  logic [DW-1:0]   mem_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .wack(wack),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory device: 64x16, write on clock edge, combinational read.
  logic [15:0] dev_mem [DEPTH];
  assign mem_rd = (mem_a[15:7] == 9'd0) ? dev_mem[mem_a[6:1]] : 16'h0000;
  always @(posedge clk) begin
    if (mem_we && mem_a[15:7] == 9'd0) dev_mem[mem_a[6:1]] <= mem_wd;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] ref_mem [DEPTH];
  int          m_last;
  bit          m_rsp_v, m_rsp_we, m_rsp_err;
  int          m_rsp_port;
  logic [15:0] m_rsp_data;
  bit          m_pend_v = 1'b0;
  bit          m_pend_we, m_pend_err;
  int          m_pend_port, m_pend_idx;
  logic [15:0] m_pend_wd, m_pend_data;
  int          m_gport = -1;
  int          wait_cnt [3];

  int          g;
  logic [15:0] ga;
  bit          glegal;
  logic [2:0]  e_rv, e_wk, e_gnt;

  // Compare process: checks outputs mid-cycle, records this cycle's grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_wack", 32'(wack), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_mem_a", 32'(mem_a), 32'd0);
      check("rst_mem_wd", 32'(mem_wd), 32'd0);
      m_pend_v = 1'b0;
      m_gport  = -1;
      for (int p = 0; p < 3; p++) wait_cnt[p] = 0;
    end else begin
      e_rv = 3'b000;
      e_wk = 3'b000;
      if (m_rsp_v) begin
        if (m_rsp_we) e_wk[m_rsp_port] = 1'b1;
        else          e_rv[m_rsp_port] = 1'b1;
      end
      check("rvalid", 32'(rvalid), 32'(e_rv));
      check("wack", 32'(wack), 32'(e_wk));
      check("err", 32'(err), 32'(m_rsp_v && m_rsp_err));
      if (m_rsp_v && !m_rsp_we) check("rdata", 32'(rdata), 32'(m_rsp_data));

      g = -1;
      for (int k = 1; k <= 3; k++) begin
        if (g < 0 && req[(m_last + k) % 3]) g = (m_last + k) % 3;
      end
      e_gnt = 3'b000;
      if (g >= 0) e_gnt[g] = 1'b1;
      check("gnt", 32'(gnt), 32'(e_gnt));

      for (int p = 0; p < 3; p++) begin
        if (req[p] && g != p) begin
          wait_cnt[p]++;
          check("fair_wait_le2", 32'(wait_cnt[p] <= 2), 32'd1);
        end else begin
          wait_cnt[p] = 0;
        end
      end

      if (g >= 0) begin
        ga     = addr[g*AW +: AW];
        glegal = (ga % 2 == 0) && (ga / 2 < DEPTH);
        check("mem_a", 32'(mem_a), 32'(ga));
        check("mem_we", 32'(mem_we), 32'(we[g] && glegal));
        if (we[g] && glegal) check("mem_wd", 32'(mem_wd), 32'(wdata[g*DW +: DW]));
        m_pend_v    = 1'b1;
        m_pend_port = g;
        m_pend_we   = we[g];
        m_pend_err  = !glegal;
        m_pend_idx  = glegal ? int'(ga / 2) : 0;
        m_pend_wd   = wdata[g*DW +: DW];
        m_pend_data = (glegal && !we[g]) ? ref_mem[ga / 2] : 16'h0000;
      end else begin
        check("idle_mem_we", 32'(mem_we), 32'd0);
        m_pend_v = 1'b0;
      end
      m_gport = g;
    end
  end

  // Model state advance at the clock edge; reset discards everything pending.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last     <= 2;
      m_rsp_v    <= 1'b0;
      m_rsp_we   <= 1'b0;
      m_rsp_err  <= 1'b0;
      m_rsp_port <= 0;
      m_rsp_data <= 16'h0000;
    end else begin
      m_rsp_v    <= m_pend_v;
      m_rsp_we   <= m_pend_we;
      m_rsp_err  <= m_pend_err;
      m_rsp_port <= m_pend_port;
      m_rsp_data <= m_pend_data;
      if (m_pend_v) begin
        m_last <= m_pend_port;
        if (m_pend_we && !m_pend_err) ref_mem[m_pend_idx] <= m_pend_wd;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0]  r_req, r_we;
  logic [15:0] r_addr [3];
  logic [15:0] r_wd [3];

  task automatic apply();
    req   = r_req;
    we    = r_we;
    addr  = {r_addr[2], r_addr[1], r_addr[0]};
    wdata = {r_wd[2], r_wd[1], r_wd[0]};
  endtask

  task automatic drv(input logic [2:0] rq, input logic [2:0] w, input logic [15:0] a, input logic [15:0] d);
    r_req = rq;
    r_we  = w;
    for (int p = 0; p < 3; p++) begin
      r_addr[p] = a;
      r_wd[p]   = d;
    end
    apply();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] gen_addr();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return {9'd0, 6'($urandom_range(0, 63)), 1'b1};
      1:       return 16'($urandom_range(64, 32767) * 2);
      2:       return 16'($urandom);
      default: return {9'd0, 6'($urandom_range(0, 15)), 1'b0};
    endcase
  endfunction

  logic [2:0] rr_seq [6];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dev_mem[i] = 16'(i * 16'h0101);
      ref_mem[i] = 16'(i * 16'h0101);
    end
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
    rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;

    // Reset with all ports requesting.
    drv(3'b111, 3'b000, 16'h0000, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      check("t_rst_gnt", 32'(gnt), 32'd0);
      check("t_rst_we", 32'(mem_we), 32'd0);
      check("t_rst_rsp", 32'({rvalid, wack}), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round robin with all three requesting.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      @(negedge clk);
      check("t_rr_gnt", 32'(gnt), 32'(rr_seq[i]));
    end
    step();
    drv(3'b100, 3'b000, 16'h0002, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge clk);
      check("t_p2_only_gnt", 32'(gnt), 32'h4);
    end

    // Single write then read.
    step(); drv(3'b010, 3'b010, 16'h0010, 16'hBEEF);
    @(negedge clk);
    check("t_wr_gnt", 32'(gnt), 32'h2);
    check("t_wr_mem_we", 32'(mem_we), 32'd1);
    check("t_wr_mem_a", 32'(mem_a), 32'h10);
    check("t_wr_mem_wd", 32'(mem_wd), 32'hBEEF);
    step(); drv(3'b001, 3'b000, 16'h0010, 16'h0000);
    @(negedge clk);
    check("t_wack", 32'(wack), 32'h2);
    check("t_rd_gnt", 32'(gnt), 32'h1);
    step(); drv(3'b000, 3'b000, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t_rvalid", 32'(rvalid), 32'h1);
    check("t_rdata", 32'(rdata), 32'hBEEF);
    check("t_rd_err", 32'(err), 32'd0);

    // Back-to-back read-after-write.
    step(); drv(3'b100, 3'b100, 16'h0004, 16'h1234);
    @(negedge clk);
    check("t_raw_gnt", 32'(gnt), 32'h4);
    step(); drv(3'b001, 3'b000, 16'h0004, 16'h0000);
    @(negedge clk);
    check("t_raw_wack", 32'(wack), 32'h4);
    step(); drv(3'b000, 3'b000, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t_raw_rvalid", 32'(rvalid), 32'h1);
    check("t_raw_rdata", 32'(rdata), 32'h1234);

    // Illegal accesses.
    step(); drv(3'b010, 3'b010, 16'h0081, 16'hDEAD);
    @(negedge clk);
    check("t_ill_gnt", 32'(gnt), 32'h2);
    check("t_ill_mem_we", 32'(mem_we), 32'd0);
    step(); drv(3'b010, 3'b010, 16'h0011, 16'hDEAD);
    @(negedge clk);
    check("t_ill_wack", 32'(wack), 32'h2);
    check("t_ill_werr", 32'(err), 32'd1);
    check("t_odd_mem_we", 32'(mem_we), 32'd0);
    step(); drv(3'b001, 3'b000, 16'h0080, 16'h0000);
    @(negedge clk);
    check("t_odd_wack_err", 32'({wack, err}), 32'h5);
    step(); drv(3'b001, 3'b000, 16'h0010, 16'h0000);
    @(negedge clk);
    check("t_oor_rvalid", 32'(rvalid), 32'h1);
    check("t_oor_err", 32'(err), 32'd1);
    check("t_oor_rdata", 32'(rdata), 32'h0);
    step(); drv(3'b000, 3'b000, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t_unchanged_rdata", 32'(rdata), 32'hBEEF);
    check("t_unchanged_err", 32'(err), 32'd0);

    // Reset in the middle of a granted read.
    step(); drv(3'b010, 3'b000, 16'h0010, 16'h0000);
    @(negedge clk);
    check("t_mid_gnt", 32'(gnt), 32'h2);
    #2 rst_n = 1'b0;
    step(); drv(3'b000, 3'b000, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t_mid_no_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(3'b111, 3'b000, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t_mid_last2_gnt", 32'(gnt), 32'h1);
    step(); drv(3'b000, 3'b000, 16'h0000, 16'h0000);

    // Randomized traffic; requests are held until granted.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int p = 0; p < 3; p++) begin
        if ((r_req[p] && m_gport == p) || !r_req[p]) begin
          if ((r_req[p] && $urandom_range(0, 1) == 1) || (!r_req[p] && $urandom_range(0, 9) < 4)) begin
            r_req[p]  = 1'b1;
            r_we[p]   = 1'($urandom_range(0, 1));
            r_addr[p] = gen_addr();
            r_wd[p]   = 16'($urandom);
          end else begin
            r_req[p] = 1'b0;
          end
        end
      end
      apply();
    end
    step(); drv(3'b000, 3'b000, 16'h0000, 16'h0000);
    repeat (3) step();

    for (int i = 0; i < DEPTH; i++) check("final_mem", 32'(dev_mem[i]), 32'(ref_mem[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
